seed_vec_source: RTL
====================

Name: seed_vec_source

Overview:
Seeded stimulus transmitter that produces the input bundle consumed by the generated fuzz-test modules: jf, nfowbodnt, duj and lto. It advances a 64-bit xorshift state once per vector and presents each vector on a valid/ready handshake. The block serves as the driving end for generated DUTs in the seed-based test flow. seed_out exposes the "seed after" value for logging.

Parameters:
DEFAULT_SEED, 64'h9E37_79B9_7F4A_7C15, reset value of the state; also substituted whenever a zero seed is loaded.
CNT_W, 16, width of the vector count and remaining counter.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
seed_load  input  1  pulse; loads seed_in into the state (honoured in IDLE only).
seed_in  input  64  new seed value.
start  input  1  pulse; begins a burst of num_vec vectors (honoured in IDLE only).
num_vec  input  CNT_W  vector count, sampled on start.
abort  input  1  terminates a burst immediately.
out_valid  output  1  vector fields are valid.
out_ready  input  1  sink accepts the vector.
jf  output  bit [2:1][1:3][4:4][2:3]  12-bit packed field.
nfowbodnt  output  reg [2:3] [3:1][1:2]  unpacked array of six 2-bit elements.
duj  output  bit [3:4]  2-bit field.
lto  output  1  1-bit field.
busy  output  1  high outside IDLE.
done  output  1  one-cycle pulse at normal burst completion.
seed_out  output  64  current state.

Behaviour:
- Next-state function xs(x):
  - x ^= x<<13; x ^= x>>7; x ^= x<<17 (64-bit, logical shifts).
- Field map from a state S:
  - jf = S[11:0], flattened MSB-first as jf[2][1][4][2] ... jf[1][3][4][3].
  - nfowbodnt[3][1] = S[23:22], [3][2] = S[21:20], [2][1] = S[19:18], [2][2] = S[17:16], [1][1] = S[15:14], [1][2] = S[13:12].
  - duj = S[25:24], with duj[3] = S[25].
  - lto = S[26].
- Reset:
  - state = DEFAULT_SEED; FSM = IDLE.
  - out_valid = 0, busy = 0, done = 0.
  - All field outputs = 0; remaining = 0.
- FSM states: IDLE, SEND, FIN.
- IDLE:
  - seed_load: state <= (seed_in == 0) ? DEFAULT_SEED : seed_in.
  - start with num_vec == 0: go to FIN; done pulses on the next cycle; no vector is emitted.
  - start with num_vec > 0: state <= xs(s0) and fields <= map(xs(s0)); remaining <= num_vec; go to SEND. out_valid rises on the cycle after start (latency 1).
  - seed_load and start in the same cycle: s0 is the newly loaded seed. Otherwise s0 is the current state.
- SEND:
  - out_valid = 1. Fields stay stable until out_ready = 1.
  - Handshake with remaining > 1: state <= xs(state), fields <= map(xs(state)), remaining decrements, out_valid stays 1. Throughput is one vector per cycle.
  - Handshake with remaining == 1: out_valid <= 0; go to FIN. State keeps the value of the last emitted vector.
- FIN: done = 1 for exactly one cycle, then IDLE.
- abort in SEND or FIN:
  - Go to IDLE next cycle; out_valid <= 0; done is not pulsed.
  - State keeps its current value; an in-flight vector is dropped.
  - abort in IDLE has no effect.
- start and seed_load outside IDLE are ignored.
- Reset asserted mid-burst returns everything to reset values asynchronously.
- busy = (FSM != IDLE).
- seed_out = state, continuously.

Decomposition:
- Package seed_vec_pkg holds:
  - typedef jf_t = bit [2:1][1:3][4:4][2:3]
  - typedef elem_t = reg [2:3]
  - typedef duj_t = bit [3:4]
  - fsm_e enum (IDLE/SEND/FIN)
  - function xs64
  - function map_fields (field slice constants)
- One sub-module, xorshift64_step: purely combinational, 64-bit in, 64-bit out. It is shared with the bench's reference model.

Test Plan:
1. Reset, then seed_load with seed_in = 1, then start with num_vec = 1 and out_ready = 1. Required response:
   - out_valid is high one cycle after start.
   - seed_out = 64'h4082_2041; jf = 12'h041.
   - nfowbodnt: [3][1] = 2'b10, [3][2] = 00, [2][1] = 00, [2][2] = 10, [1][1] = 00, [1][2] = 10.
   - duj = 0, lto = 0.
   - done pulses once.
2. seed_load with seed_in = 0. Required response: seed_out = DEFAULT_SEED.
3. num_vec = 4 with out_ready held low for 3 cycles, then high. Required response:
   - Fields are stable while stalled.
   - 4 vectors are accepted on 4 consecutive cycles.
   - Each vector equals the reference xs chain.
4. start with num_vec = 0. Required response: done pulses on the next cycle; out_valid never rises.
5. abort after 2 of 5 vectors. Required response:
   - out_valid drops and busy drops; no done pulse.
   - A subsequent start continues the xs chain from the last emitted state.
6. Assert rst mid-burst. Required response:
   - All outputs clear immediately.
   - seed_out = DEFAULT_SEED.
   - start and seed_load pulses issued while busy are ignored.

Source files
------------

// File: rtl/seed_vec_pkg.sv
// Shared types and helpers for the seeded vector source.
// The xorshift step and the state-to-field slicing are kept here so every consumer agrees on them.
package seed_vec_pkg;

  typedef bit [2:1][1:3][4:4][2:3] jf_t;
  typedef reg [2:3]                elem_t;
  typedef bit [3:4]                duj_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } fsm_e;

  localparam logic [63:0] SEED_DEFAULT = 64'h9E37_79B9_7F4A_7C15;

  localparam int JF_LSB  = 0;
  localparam int NFO_LSB = 12;
  localparam int DUJ_LSB = 24;
  localparam int LTO_BIT = 26;

  // nfo holds the six 2-bit elements flattened [3][1] (MSB) down to [1][2] (LSB).
  typedef struct packed {
    logic        lto;
    duj_t        duj;
    logic [11:0] nfo;
    jf_t         jf;
  } fields_t;

  function automatic logic [63:0] xs64(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic fields_t map_fields(input logic [63:0] s);
    fields_t f;
    f.jf  = s[JF_LSB +: 12];
    f.nfo = s[NFO_LSB +: 12];
    f.duj = s[DUJ_LSB +: 2];
    f.lto = s[LTO_BIT];
    return f;
  endfunction

endpackage

// File: rtl/xorshift64_step.sv
// One combinational xorshift64 advance; used for both burst start and per-vector stepping.
module xorshift64_step
  import seed_vec_pkg::*;
(
  input  logic [63:0] x,
  output logic [63:0] y
);

  assign y = xs64(x);

endmodule

// File: rtl/seed_vec_source.sv
// Seeded stimulus transmitter: steps a 64-bit xorshift state per vector and
// presents the derived jf/nfowbodnt/duj/lto bundle on a valid/ready handshake.
module seed_vec_source
  import seed_vec_pkg::*;
#(
  parameter logic [63:0] DEFAULT_SEED = SEED_DEFAULT,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [63:0]      seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output jf_t              jf,
  output elem_t            nfowbodnt [3:1][1:2],
  output duj_t             duj,
  output logic             lto,
  output logic             busy,
  output logic             done,
  output logic [63:0]      seed_out
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SEND = SEND;
  localparam logic [1:0] S_FIN  = FIN;

  logic [1:0]       fsm_reg;
  logic [63:0]      state_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic             out_valid_reg;
  fields_t          fields_reg;

  logic [63:0] load_val;
  logic [63:0] step_in;
  logic [63:0] step_out;
  logic        handshake;

  assign load_val  = (seed_in == 64'd0) ? DEFAULT_SEED : seed_in;
  // A seed loaded together with start becomes s0 for that burst.
  assign step_in   = (fsm_reg == S_IDLE && seed_load) ? load_val : state_reg;
  assign handshake = out_valid_reg & out_ready;

  xorshift64_step u_step (
    .x (step_in),
    .y (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= S_IDLE;
      state_reg     <= DEFAULT_SEED;
      remaining_reg <= '0;
      out_valid_reg <= 1'b0;
      fields_reg    <= '0;
    end else begin
      case (fsm_reg)
        S_IDLE: begin
          if (start) begin
            if (num_vec == '0) begin
              if (seed_load) state_reg <= load_val;
              fsm_reg <= S_FIN;
            end else begin
              state_reg     <= step_out;
              fields_reg    <= map_fields(step_out);
              remaining_reg <= num_vec;
              out_valid_reg <= 1'b1;
              fsm_reg       <= S_SEND;
            end
          end else if (seed_load) begin
            state_reg <= load_val;
          end
        end
        S_SEND: begin
          // Abort outranks a coincident handshake: the in-flight vector is dropped.
          if (abort) begin
            out_valid_reg <= 1'b0;
            remaining_reg <= '0;
            fsm_reg       <= S_IDLE;
          end else if (handshake) begin
            remaining_reg <= remaining_reg - CNT_W'(1);
            if (remaining_reg > CNT_W'(1)) begin
              state_reg  <= step_out;
              fields_reg <= map_fields(step_out);
            end else begin
              out_valid_reg <= 1'b0;
              fsm_reg       <= S_FIN;
            end
          end
        end
        S_FIN: begin
          fsm_reg <= S_IDLE;
        end
        default: begin
          fsm_reg       <= S_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign busy      = (fsm_reg != S_IDLE);
  assign done      = (fsm_reg == S_FIN) && !abort;
  assign seed_out  = state_reg;
  assign jf        = fields_reg.jf;
  assign duj       = fields_reg.duj;
  assign lto       = fields_reg.lto;

  for (genvar gi = 1; gi <= 3; gi++) begin : g_row
    for (genvar gj = 1; gj <= 2; gj++) begin : g_col
      assign nfowbodnt[gi][gj] = fields_reg.nfo[(gi-1)*4 + (2-gj)*2 +: 2];
    end
  end

endmodule
